// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : issue_scoreboard
// Brief   : Decode-to-execute issue control with per-register pending-write
//           counters, RAW/WAW/window stalls, CSR serialisation and branch hold.
// Rev     : 1.0
// ============================================================================
module issue_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int MAX_OUT = 4,
    parameter int OUT_W   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_s_branch,
    input  logic             dec_s_jump,
    input  logic             dec_s_csr,
    output logic             issue_valid,
    input  logic             issue_ready,
    input  logic             br_resolve,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic [OUT_W-1:0] outstanding,
    output logic             busy,
    output logic             wb_err
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        SERIAL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_full = '1;
    localparam logic [OUT_W-1:0] c_max_out  = OUT_W'(MAX_OUT);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_pend [32];
    logic [OUT_W-1:0] r_outstanding;
    logic             r_wb_err;

    logic [CNT_W-1:0] w_pend_rs1;
    logic [CNT_W-1:0] w_pend_rs2;
    logic [CNT_W-1:0] w_pend_rd;
    logic [CNT_W-1:0] w_pend_wb;
    logic             w_can_issue;
    logic             w_fire;
    logic             w_fire_trk;
    logic             w_wb_hit;
    logic             w_wb_miss;

    // x0 reads as zero regardless of the (never written) entry 0
    always_comb begin
        w_pend_rs1 = (dec_rs1 != 5'd0) ? r_pend[dec_rs1] : '0;
        w_pend_rs2 = (dec_rs2 != 5'd0) ? r_pend[dec_rs2] : '0;
        w_pend_rd  = (dec_rd  != 5'd0) ? r_pend[dec_rd]  : '0;
        w_pend_wb  = (wb_rd   != 5'd0) ? r_pend[wb_rd]   : '0;
    end

    assign w_can_issue = !reset
                       && (r_state == RUN)
                       && (w_pend_rs1 == '0)
                       && (w_pend_rs2 == '0)
                       && ((dec_rd == 5'd0) || (w_pend_rd != c_cnt_full))
                       && ((dec_rd == 5'd0) || (r_outstanding < c_max_out))
                       && (!dec_s_csr || (r_outstanding == '0));

    assign issue_valid = dec_valid & w_can_issue;
    assign dec_ready   = w_can_issue & issue_ready;
    assign w_fire      = dec_valid & dec_ready;
    assign w_fire_trk  = w_fire && (dec_rd != 5'd0);
    assign w_wb_hit    = wb_valid && (wb_rd != 5'd0) && (w_pend_wb != '0);
    assign w_wb_miss   = wb_valid && (wb_rd != 5'd0) && (w_pend_wb == '0);

    // A fire and a retire on the same register cancel out
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_pend[i] <= '0;
            end
            r_outstanding <= '0;
            r_wb_err      <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_fire_trk && (dec_rd == 5'(i)) && !(w_wb_hit && (wb_rd == 5'(i)))) begin
                    r_pend[i] <= r_pend[i] + 1'b1;
                end else if (w_wb_hit && (wb_rd == 5'(i)) && !(w_fire_trk && (dec_rd == 5'(i)))) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
            end
            if (w_fire_trk && !w_wb_hit) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (w_wb_hit && !w_fire_trk) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            if (w_wb_miss) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Control transfers win over CSR when both flags are set
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_fire && (dec_s_branch || dec_s_jump)) begin
                    w_state_next = BR_WAIT;
                end else if (w_fire && dec_s_csr) begin
                    w_state_next = SERIAL;
                end
            end
            BR_WAIT: begin
                if (br_resolve) begin
                    w_state_next = RUN;
                end
            end
            SERIAL: begin
                if (r_outstanding == '0) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    assign outstanding = r_outstanding;
    assign busy        = (r_outstanding != '0);
    assign wb_err      = r_wb_err;

endmodule
`default_nettype wire
